bcd_mod_cnt: RTL and testbench

- Parametrised two-digit BCD modulo counter for the clock datapath: seconds, minutes and hours, chained through carry/borrow.
- Adds a configurable modulus, up/down counting, synchronous BCD preset for time-setting, a set-mode increment, and terminal-count flags.
- Instances cascade directly: CA/BR of one stage drives STEP of the next.

---
 rtl/bcd_pkg.sv | 44 ++++
 rtl/bcd_mod_cnt_if.sv | 30 +++
 rtl/bcd_digit_step.sv | 24 ++
 rtl/bcd_mod_cnt.sv | 115 +++++++++++
 tb/tb_bcd_mod_cnt.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD digit types and helpers for the clock datapath counters.
package bcd_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    logic c;
    bcd_t d;
  } bcd_step_t;

  localparam bcd_t BCD_MAX = 4'd9;

  function automatic bcd_step_t bcd_inc(input bcd_t d);
    bcd_step_t r;
    if (d >= BCD_MAX) begin
      r.c = 1'b1;
      r.d = 4'd0;
    end else begin
      r.c = 1'b0;
      r.d = d + 4'd1;
    end
    return r;
  endfunction

  function automatic bcd_step_t bcd_dec(input bcd_t d);
    bcd_step_t r;
    if (d == 4'd0) begin
      r.c = 1'b1;
      r.d = BCD_MAX;
    end else begin
      r.c = 1'b0;
      r.d = d - 4'd1;
    end
    return r;
  endfunction

  function automatic logic [6:0] bcd_to_bin(
    input bcd_t h,
    input bcd_t l
  );
    return 7'(h) * 7'd10 + 7'(l);
  endfunction

endpackage

// File: rtl/bcd_mod_cnt_if.sv
// Control and status bundle of one BCD modulo counter stage.
interface bcd_mod_cnt_if;
  import bcd_pkg::*;

  logic CLR;
  logic EN;
  logic STEP;
  logic UP;
  logic LD;
  bcd_t LDH;
  bcd_t LDL;
  logic INC;
  bcd_t QH;
  bcd_t QL;
  logic CA;
  logic BR;
  logic TC;
  logic ERR;

  modport master (
    output CLR, EN, STEP, UP, LD, LDH, LDL, INC,
    input  QH, QL, CA, BR, TC, ERR
  );

  modport slave (
    input  CLR, EN, STEP, UP, LD, LDH, LDL, INC,
    output QH, QL, CA, BR, TC, ERR
  );

endinterface

// File: rtl/bcd_digit_step.sv
// One BCD digit: combinational next value with carry/borrow out.
module bcd_digit_step
  import bcd_pkg::*;
(
  input  bcd_t d,
  input  logic up,
  input  logic ci,
  output bcd_t q,
  output logic co
);

  bcd_step_t s;

  always_comb begin
    s  = up ? bcd_inc(d) : bcd_dec(d);
    q  = d;
    co = 1'b0;
    if (ci) begin
      q  = s.d;
      co = s.c;
    end
  end

endmodule

// File: rtl/bcd_mod_cnt.sv
// Two-digit BCD modulo counter with preset, set-mode increment and
// same-cycle carry/borrow for direct cascading.
module bcd_mod_cnt
  import bcd_pkg::*;
#(
  parameter int MOD       = 60,
  parameter int INC_CARRY = 0,
  parameter int LD_CHECK  = 1
) (
  input logic         CLK,
  input logic         RST,
  bcd_mod_cnt_if.slave bus
);

  if (MOD < 2 || MOD > 100) begin : g_bad_mod
    $error("bcd_mod_cnt: MOD must be in 2..100");
  end

  localparam bcd_t MAXH = bcd_t'((MOD - 1) / 10);
  localparam bcd_t MAXL = bcd_t'((MOD - 1) % 10);
  localparam logic [6:0] VMAX = 7'(MOD - 1);
  localparam logic [6:0] VMOD = 7'(MOD);

  bcd_t qh, ql;
  logic err;
  logic [6:0] v;
  logic at_max, at_zero;
  logic dir;
  bcd_t u_q, t_q;
  logic u_co, t_co_unused;
  bcd_t n_h, n_l;
  logic ld_ok;
  logic ca_cnt, ca_inc;

  assign v       = bcd_to_bin(qh, ql);
  assign at_max  = (v == VMAX);
  assign at_zero = (v == 7'd0);

  // INC always moves upward whatever UP says
  assign dir = bus.INC | bus.UP;

  bcd_digit_step u_units (
    .d  (ql),
    .up (dir),
    .ci (1'b1),
    .q  (u_q),
    .co (u_co)
  );

  bcd_digit_step u_tens (
    .d  (qh),
    .up (dir),
    .ci (u_co),
    .q  (t_q),
    .co (t_co_unused)
  );

  always_comb begin
    n_h = t_q;
    n_l = u_q;
    if (dir && at_max) begin
      n_h = 4'd0;
      n_l = 4'd0;
    end else if (!dir && at_zero) begin
      n_h = MAXH;
      n_l = MAXL;
    end
  end

  always_comb begin
    ld_ok = 1'b1;
    if (LD_CHECK != 0) begin
      ld_ok = (bus.LDH <= BCD_MAX)
            && (bus.LDL <= BCD_MAX)
            && (bcd_to_bin(bus.LDH, bus.LDL) < VMOD);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      qh  <= 4'd0;
      ql  <= 4'd0;
      err <= 1'b0;
    end else begin
      err <= 1'b0;
      if (bus.CLR) begin
        qh <= 4'd0;
        ql <= 4'd0;
      end else if (bus.LD) begin
        if (ld_ok) begin
          qh <= bus.LDH;
          ql <= bus.LDL;
        end else begin
          err <= 1'b1;
        end
      end else if (bus.INC || (bus.EN && bus.STEP)) begin
        qh <= n_h;
        ql <= n_l;
      end
    end
  end

  assign ca_cnt = bus.EN & bus.STEP & bus.UP & at_max;
  assign ca_inc = (INC_CARRY != 0) & bus.INC & at_max;

  assign bus.CA = ~RST & ~bus.CLR & ~bus.LD & (ca_cnt | ca_inc);
  assign bus.BR = ~RST & ~bus.CLR & ~bus.LD & ~bus.INC
                & bus.EN & bus.STEP & ~bus.UP & at_zero;

  assign bus.TC  = bus.UP ? at_max : at_zero;
  assign bus.QH  = qh;
  assign bus.QL  = ql;
  assign bus.ERR = err;

endmodule

// File: tb/tb_bcd_mod_cnt.sv
// Directed bench for bcd_mod_cnt: count, wrap, preset, INC, priority, chain.
module tb_bcd_mod_cnt;
  import bcd_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  bcd_mod_cnt_if b60 ();
  bcd_mod_cnt_if b60c ();
  bcd_mod_cnt_if b24 ();
  bcd_mod_cnt_if cs ();
  bcd_mod_cnt_if cm ();
  bcd_mod_cnt_if ch ();

  assign cm.STEP = cs.CA;
  assign ch.STEP = cm.CA;

  bcd_mod_cnt #(.MOD(60)) u60 (.CLK(CLK), .RST(RST), .bus(b60));
  bcd_mod_cnt #(.MOD(60), .INC_CARRY(1)) u60c (.CLK(CLK), .RST(RST), .bus(b60c));
  bcd_mod_cnt #(.MOD(24)) u24 (.CLK(CLK), .RST(RST), .bus(b24));
  bcd_mod_cnt #(.MOD(60)) us (.CLK(CLK), .RST(RST), .bus(cs));
  bcd_mod_cnt #(.MOD(60)) um (.CLK(CLK), .RST(RST), .bus(cm));
  bcd_mod_cnt #(.MOD(24)) uh (.CLK(CLK), .RST(RST), .bus(ch));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    {b60.CLR, b60.EN, b60.STEP, b60.UP, b60.LD, b60.INC} = '0;
    b60.LDH = 4'd0; b60.LDL = 4'd0;
    {b60c.CLR, b60c.EN, b60c.STEP, b60c.UP, b60c.LD, b60c.INC} = '0;
    b60c.LDH = 4'd0; b60c.LDL = 4'd0;
    {b24.CLR, b24.EN, b24.STEP, b24.UP, b24.LD, b24.INC} = '0;
    b24.LDH = 4'd0; b24.LDL = 4'd0;
    {cs.CLR, cs.EN, cs.STEP, cs.UP, cs.LD, cs.INC} = '0;
    cs.LDH = 4'd0; cs.LDL = 4'd0;
    {cm.CLR, cm.EN, cm.UP, cm.LD, cm.INC} = '0;
    cm.LDH = 4'd0; cm.LDL = 4'd0;
    {ch.CLR, ch.EN, ch.UP, ch.LD, ch.INC} = '0;
    ch.LDH = 4'd0; ch.LDL = 4'd0;
    #1;
    checks++;
    if ({b60.QH, b60.QL} !== 8'h00) begin
      errors++;
      $display("FAIL reset_value: got %h want 00", {b60.QH, b60.QL});
    end
    checks++;
    if ({b60.ERR, b60.CA, b60.BR, b60.TC} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_flags: got ERR/CA/BR/TC=%b want 0001",
               {b60.ERR, b60.CA, b60.BR, b60.TC});
    end
    @(negedge CLK);
    RST = 1'b0;
    tick();
  endtask

  task automatic test_count_up();
    b60.LD = 1'b1; b60.LDH = 4'd5; b60.LDL = 4'd8;
    tick();
    b60.LD = 1'b0;
    b60.UP = 1'b1; b60.EN = 1'b1; b60.STEP = 1'b1;
    #1;
    checks++;
    if ({b60.QH, b60.QL, b60.CA, b60.TC} !== 10'h160) begin
      errors++;
      $display("FAIL up_58: got V=%h CA=%b TC=%b want 58 0 0",
               {b60.QH, b60.QL}, b60.CA, b60.TC);
    end
    tick();
    checks++;
    if ({b60.QH, b60.QL, b60.CA, b60.TC} !== 10'h167) begin
      errors++;
      $display("FAIL up_59: got V=%h CA=%b TC=%b want 59 1 1",
               {b60.QH, b60.QL}, b60.CA, b60.TC);
    end
    tick();
    checks++;
    if ({b60.QH, b60.QL, b60.CA, b60.TC} !== 10'h000) begin
      errors++;
      $display("FAIL up_wrap: got V=%h CA=%b TC=%b want 00 0 0",
               {b60.QH, b60.QL}, b60.CA, b60.TC);
    end
    b60.EN = 1'b0; b60.STEP = 1'b0;
  endtask

  task automatic test_count_down();
    b24.LD = 1'b1; b24.LDH = 4'd0; b24.LDL = 4'd1;
    tick();
    b24.LD = 1'b0;
    b24.UP = 1'b0; b24.EN = 1'b1; b24.STEP = 1'b1;
    #1;
    checks++;
    if ({b24.QH, b24.QL, b24.BR, b24.TC} !== 10'h004) begin
      errors++;
      $display("FAIL dn_01: got V=%h BR=%b TC=%b want 01 0 0",
               {b24.QH, b24.QL}, b24.BR, b24.TC);
    end
    tick();
    checks++;
    if ({b24.QH, b24.QL, b24.BR, b24.TC} !== 10'h003) begin
      errors++;
      $display("FAIL dn_00: got V=%h BR=%b TC=%b want 00 1 1",
               {b24.QH, b24.QL}, b24.BR, b24.TC);
    end
    tick();
    checks++;
    if ({b24.QH, b24.QL, b24.BR, b24.CA} !== 10'h08C) begin
      errors++;
      $display("FAIL dn_wrap: got V=%h BR=%b CA=%b want 23 0 0",
               {b24.QH, b24.QL}, b24.BR, b24.CA);
    end
    tick();
    checks++;
    if ({b24.QH, b24.QL} !== 8'h22) begin
      errors++;
      $display("FAIL dn_22: got V=%h want 22", {b24.QH, b24.QL});
    end
    b24.EN = 1'b0; b24.STEP = 1'b0;
  endtask

  task automatic test_load();
    b60.LD = 1'b1; b60.LDH = 4'd1; b60.LDL = 4'd7;
    tick();
    b60.LDH = 4'd6; b60.LDL = 4'd0;
    tick();
    checks++;
    if ({b60.QH, b60.QL, b60.ERR} !== 9'h02F) begin
      errors++;
      $display("FAIL ld_reject: got V=%h ERR=%b want 17 1",
               {b60.QH, b60.QL}, b60.ERR);
    end
    b60.LDH = 4'd4; b60.LDL = 4'd5;
    tick();
    checks++;
    if ({b60.QH, b60.QL, b60.ERR} !== 9'h08A) begin
      errors++;
      $display("FAIL ld_45: got V=%h ERR=%b want 45 0",
               {b60.QH, b60.QL}, b60.ERR);
    end
    b60.LDH = 4'd1; b60.LDL = 4'hA;
    tick();
    checks++;
    if ({b60.QH, b60.QL, b60.ERR} !== 9'h08B) begin
      errors++;
      $display("FAIL ld_baddigit: got V=%h ERR=%b want 45 1",
               {b60.QH, b60.QL}, b60.ERR);
    end
    b60.LD = 1'b0;
    b60.UP = 1'b1; b60.STEP = 1'b1;
    tick();
    checks++;
    if ({b60.QH, b60.QL, b60.ERR, b60.CA} !== 10'h114) begin
      errors++;
      $display("FAIL hold_en0: got V=%h ERR=%b CA=%b want 45 0 0",
               {b60.QH, b60.QL}, b60.ERR, b60.CA);
    end
    b60.STEP = 1'b0; b60.UP = 1'b0;
  endtask

  task automatic test_inc();
    b60.LD = 1'b1; b60.LDH = 4'd5; b60.LDL = 4'd9;
    b60c.LD = 1'b1; b60c.LDH = 4'd5; b60c.LDL = 4'd9;
    tick();
    b60.LD = 1'b0; b60c.LD = 1'b0;
    b60.INC = 1'b1; b60c.INC = 1'b1;
    #1;
    checks++;
    if (b60.CA !== 1'b0) begin
      errors++;
      $display("FAIL inc_noca: got CA=%b want 0", b60.CA);
    end
    checks++;
    if (b60c.CA !== 1'b1) begin
      errors++;
      $display("FAIL inc_ca: got CA=%b want 1", b60c.CA);
    end
    tick();
    checks++;
    if ({b60.QH, b60.QL, b60c.QH, b60c.QL} !== 16'h0000) begin
      errors++;
      $display("FAIL inc_wrap: got %h/%h want 00/00",
               {b60.QH, b60.QL}, {b60c.QH, b60c.QL});
    end
    b60c.INC = 1'b0;
    b60.LD = 1'b1; b60.LDH = 4'd0; b60.LDL = 4'd9;
    tick();
    b60.LD = 1'b0;
    tick();
    checks++;
    if ({b60.QH, b60.QL} !== 8'h10) begin
      errors++;
      $display("FAIL inc_digit: got V=%h want 10", {b60.QH, b60.QL});
    end
    b60.INC = 1'b0;
  endtask

  task automatic test_priority();
    b60.LD = 1'b1; b60.LDH = 4'd5; b60.LDL = 4'd9;
    tick();
    b60.UP = 1'b1; b60.EN = 1'b1; b60.STEP = 1'b1;
    b60.CLR = 1'b1; b60.LDH = 4'd4; b60.LDL = 4'd5;
    #1;
    checks++;
    if (b60.CA !== 1'b0) begin
      errors++;
      $display("FAIL prio_ca: got CA=%b want 0", b60.CA);
    end
    tick();
    checks++;
    if ({b60.QH, b60.QL, b60.ERR} !== 9'h000) begin
      errors++;
      $display("FAIL prio_clr: got V=%h ERR=%b want 00 0",
               {b60.QH, b60.QL}, b60.ERR);
    end
    b60.CLR = 1'b0;
    tick();
    checks++;
    if ({b60.QH, b60.QL} !== 8'h45) begin
      errors++;
      $display("FAIL prio_ld: got V=%h want 45", {b60.QH, b60.QL});
    end
    b60.LD = 1'b0;
  endtask

  task automatic test_reset_mid();
    b60.LD = 1'b1; b60.LDH = 4'd3; b60.LDL = 4'd2;
    tick();
    b60.LD = 1'b0;
    tick();
    checks++;
    if ({b60.QH, b60.QL} !== 8'h33) begin
      errors++;
      $display("FAIL mid_33: got V=%h want 33", {b60.QH, b60.QL});
    end
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if ({b60.QH, b60.QL, b60.CA} !== 9'h000) begin
      errors++;
      $display("FAIL mid_rst: got V=%h CA=%b want 00 0",
               {b60.QH, b60.QL}, b60.CA);
    end
    b60.EN = 1'b0; b60.STEP = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    tick();
  endtask

  task automatic test_chain();
    cs.UP = 1'b1; cm.UP = 1'b1; ch.UP = 1'b1;
    cm.EN = 1'b1; ch.EN = 1'b1; cs.EN = 1'b1;
    cs.LD = 1'b1; cs.LDH = 4'd5; cs.LDL = 4'd9;
    cm.LD = 1'b1; cm.LDH = 4'd5; cm.LDL = 4'd9;
    ch.LD = 1'b1; ch.LDH = 4'd2; ch.LDL = 4'd3;
    tick();
    cs.LD = 1'b0; cm.LD = 1'b0; ch.LD = 1'b0;
    cs.STEP = 1'b1;
    #1;
    checks++;
    if ({cs.CA, cm.CA, ch.CA} !== 3'b111) begin
      errors++;
      $display("FAIL chain_ca: got %b want 111", {cs.CA, cm.CA, ch.CA});
    end
    tick();
    checks++;
    if ({ch.QH, ch.QL, cm.QH, cm.QL, cs.QH, cs.QL} !== 24'h000000) begin
      errors++;
      $display("FAIL chain_wrap: got %h want 000000",
               {ch.QH, ch.QL, cm.QH, cm.QL, cs.QH, cs.QL});
    end
    tick();
    checks++;
    if ({ch.QH, ch.QL, cm.QH, cm.QL, cs.QH, cs.QL} !== 24'h000001) begin
      errors++;
      $display("FAIL chain_next: got %h want 000001",
               {ch.QH, ch.QL, cm.QH, cm.QL, cs.QH, cs.QL});
    end
    cs.STEP = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_inc();
    test_priority();
    test_reset_mid();
    test_chain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
